// File: rtl/btb_assoc_pkg.sv
//------------------------------------------------------------------------------
// btb_assoc_pkg
// Shared sizes, entry layout, flush-walker states and counter helpers for the
// set-associative branch target buffer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package btb_assoc_pkg;

    localparam int INSTR_MEM_IDX_W = 10;
    localparam int BTB_SETS        = 16;
    localparam int BTB_WAYS        = 2;

    typedef enum logic [0:0] {
        BTB_IDLE  = 1'b0,
        BTB_FLUSH = 1'b1
    } btb_fsm_e;

    typedef struct packed {
        logic                       valid;
        logic [INSTR_MEM_IDX_W-1:0] tag;
        logic [INSTR_MEM_IDX_W-1:0] target;
        logic [1:0]                 ctr;
    } btb_entry_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btb_victim_sel.sv
//------------------------------------------------------------------------------
// btb_victim_sel
// Picks the allocation way for one set: lowest invalid way, else the
// round-robin pointer (flagged as an eviction).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btb_victim_sel
    import btb_assoc_pkg::*;
#(
    parameter int WAYS  = BTB_WAYS,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]  i_valid,
    input  logic [WAY_W-1:0] i_rr,
    output logic [WAY_W-1:0] o_way,
    output logic             o_evict
);

    always_comb begin
        o_evict = &i_valid;
        o_way   = i_rr;
        // Descending scan so the lowest invalid way is the last assignment.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                o_way = WAY_W'(w);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/btb_assoc.sv
//------------------------------------------------------------------------------
// btb_assoc
// Set-associative BTB with round-robin replacement and a one-set-per-cycle
// flush walker. Optional 2-bit direction counters: define BTB_DIR_CTR_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int PC_W = INSTR_MEM_IDX_W,
    parameter int SETS = BTB_SETS,
    parameter int WAYS = BTB_WAYS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            btb_hit,
    output logic [PC_W-1:0] btb_target,
    input  logic            update_valid,
    input  logic [PC_W-1:0] update_pc,
    input  logic [PC_W-1:0] update_target,
    input  logic            update_taken,
    input  logic            flush_req,
    output logic            flush_busy
);

    localparam int SET_IDX_W = $clog2(SETS);
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAYS-1:0]      r_valid  [SETS];
    logic [PC_W-1:0]      r_tag    [SETS][WAYS];
    logic [PC_W-1:0]      r_target [SETS][WAYS];
    logic [WAY_W-1:0]     r_rr     [SETS];
`ifdef BTB_DIR_CTR_EN
    logic [1:0]           r_ctr    [SETS][WAYS];
`endif
    btb_fsm_e             r_state;
    btb_fsm_e             w_state_nxt;
    logic [SET_IDX_W-1:0] r_fcnt;

    logic [SET_IDX_W-1:0] w_f_set;
    logic [SET_IDX_W-1:0] w_u_set;
    logic                 w_f_match;
    logic [WAY_W-1:0]     w_f_way;
    logic                 w_f_pred;
    logic                 w_u_hit;
    logic [WAY_W-1:0]     w_u_way;
    logic [WAY_W-1:0]     w_vic_way;
    logic                 w_vic_evict;
    logic [WAY_W-1:0]     w_wr_way;
    logic                 w_upd_ok;

    assign w_f_set  = fetch_pc[SET_IDX_W-1:0];
    assign w_u_set  = update_pc[SET_IDX_W-1:0];
    assign w_upd_ok = update_valid && !flush_req && (r_state == BTB_IDLE);
    assign w_wr_way = w_u_hit ? w_u_way : w_vic_way;

    // Descending scans: the lowest matching way wins.
    always_comb begin
        w_f_match = 1'b0;
        w_f_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_f_set][w] && (r_tag[w_f_set][w] == fetch_pc)) begin
                w_f_match = 1'b1;
                w_f_way   = WAY_W'(w);
            end
        end
    end

    always_comb begin
        w_u_hit = 1'b0;
        w_u_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_u_set][w] && (r_tag[w_u_set][w] == update_pc)) begin
                w_u_hit = 1'b1;
                w_u_way = WAY_W'(w);
            end
        end
    end

`ifdef BTB_DIR_CTR_EN
    assign w_f_pred = r_ctr[w_f_set][w_f_way][1];
`else
    assign w_f_pred = 1'b1;
`endif

    assign btb_hit    = (r_state == BTB_IDLE) && w_f_match && w_f_pred;
    assign btb_target = btb_hit ? r_target[w_f_set][w_f_way] : '0;
    assign flush_busy = (r_state == BTB_FLUSH);

    btb_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .i_valid (r_valid[w_u_set]),
        .i_rr    (r_rr[w_u_set]),
        .o_way   (w_vic_way),
        .o_evict (w_vic_evict)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BTB_IDLE:  if (flush_req) w_state_nxt = BTB_FLUSH;
            BTB_FLUSH: if (r_fcnt == SET_IDX_W'(SETS - 1)) w_state_nxt = BTB_IDLE;
            default:   w_state_nxt = BTB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BTB_IDLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == BTB_FLUSH) begin
                r_fcnt <= r_fcnt + SET_IDX_W'(1);
            end else if (flush_req) begin
                r_fcnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
`ifdef BTB_DIR_CTR_EN
                for (int w = 0; w < WAYS; w++) r_ctr[s][w] <= 2'b00;
`endif
            end
        end else if (r_state == BTB_FLUSH) begin
            r_valid[r_fcnt] <= '0;
            r_rr[r_fcnt]    <= '0;
`ifdef BTB_DIR_CTR_EN
            for (int w = 0; w < WAYS; w++) r_ctr[r_fcnt][w] <= 2'b00;
`endif
        end else if (w_upd_ok) begin
            if (w_u_hit) begin
`ifdef BTB_DIR_CTR_EN
                r_ctr[w_u_set][w_u_way] <= update_taken ? sat_inc(r_ctr[w_u_set][w_u_way])
                                                        : sat_dec(r_ctr[w_u_set][w_u_way]);
`else
                // Without counters a not-taken outcome simply forgets the branch.
                if (!update_taken) r_valid[w_u_set][w_u_way] <= 1'b0;
`endif
            end else if (update_taken) begin
                r_valid[w_u_set][w_vic_way] <= 1'b1;
`ifdef BTB_DIR_CTR_EN
                r_ctr[w_u_set][w_vic_way] <= 2'b10;
`endif
                if (w_vic_evict && (WAYS > 1)) begin
                    r_rr[w_u_set] <= r_rr[w_u_set] + WAY_W'(1);
                end
            end
        end
    end

    // Tag and target arrays carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_upd_ok && update_taken) begin
            r_target[w_u_set][w_wr_way] <= update_target;
            if (!w_u_hit) begin
                r_tag[w_u_set][w_wr_way] <= update_pc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_btb_assoc.sv
//------------------------------------------------------------------------------
// tb_btb_assoc
// Scoreboard bench for btb_assoc: directed scenarios followed by random
// traffic, checked against an array-based model of the BTB rules.
//------------------------------------------------------------------------------
`default_nettype none

module tb_btb_assoc;

    localparam int PC_W = 10;
    localparam int SETS = 16;
    localparam int WAYS = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PC_W-1:0] fetch_pc = '0;
    logic            btb_hit;
    logic [PC_W-1:0] btb_target;
    logic            update_valid = 1'b0;
    logic [PC_W-1:0] update_pc = '0;
    logic [PC_W-1:0] update_target = '0;
    logic            update_taken = 1'b0;
    logic            flush_req = 1'b0;
    logic            flush_busy;

    always #5 clk = ~clk;

    btb_assoc #(.PC_W(PC_W), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_pc      (fetch_pc),
        .btb_hit       (btb_hit),
        .btb_target    (btb_target),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken),
        .flush_req     (flush_req),
        .flush_busy    (flush_busy)
    );

    typedef struct {
        bit              chk;
        bit              hit;
        logic [PC_W-1:0] tgt;
        bit              busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model
    bit              m_known = 0;
    bit              m_valid [SETS][WAYS];
    logic [PC_W-1:0] m_tag   [SETS][WAYS];
    logic [PC_W-1:0] m_tgt   [SETS][WAYS];
    int              m_ctr   [SETS][WAYS];
    int              m_rr    [SETS];
    int              m_flush_left = 0;

    function automatic int m_find(input logic [PC_W-1:0] pc);
        int s = int'(pc) % SETS;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == pc) return w;
        return -1;
    endfunction

    function automatic void m_predict(input logic [PC_W-1:0] pc, output bit hit,
                                      output logic [PC_W-1:0] tgt);
        int s = int'(pc) % SETS;
        int w = m_find(pc);
        hit = 0;
        tgt = '0;
        if (w >= 0 && m_flush_left == 0) begin
`ifdef BTB_DIR_CTR_EN
            hit = (m_ctr[s][w] >= 2);
`else
            hit = 1;
`endif
            if (hit) tgt = m_tgt[s][w];
        end
    endfunction

    task automatic m_step(input bit r, input bit fr, input bit uv, input logic [PC_W-1:0] upc,
                          input logic [PC_W-1:0] ut, input bit tk);
        int s, w;
        if (r) begin
            m_known = 1;
            m_flush_left = 0;
            for (int i = 0; i < SETS; i++) begin
                m_rr[i] = 0;
                for (int j = 0; j < WAYS; j++) begin
                    m_valid[i][j] = 0;
                    m_ctr[i][j] = 0;
                end
            end
        end else if (m_flush_left > 0) begin
            s = SETS - m_flush_left;
            m_rr[s] = 0;
            for (int j = 0; j < WAYS; j++) begin
                m_valid[s][j] = 0;
                m_ctr[s][j] = 0;
            end
            m_flush_left--;
        end else if (fr) begin
            m_flush_left = SETS;
        end else if (uv) begin
            s = int'(upc) % SETS;
            w = m_find(upc);
            if (w >= 0) begin
                if (tk) begin
                    m_tgt[s][w] = ut;
                    if (m_ctr[s][w] < 3) m_ctr[s][w]++;
                end else begin
`ifdef BTB_DIR_CTR_EN
                    if (m_ctr[s][w] > 0) m_ctr[s][w]--;
`else
                    m_valid[s][w] = 0;
`endif
                end
            end else if (tk) begin
                w = -1;
                for (int j = WAYS - 1; j >= 0; j--) if (!m_valid[s][j]) w = j;
                if (w < 0) begin
                    w = m_rr[s];
                    m_rr[s] = (m_rr[s] + 1) % WAYS;
                end
                m_valid[s][w] = 1;
                m_tag[s][w]   = upc;
                m_tgt[s][w]   = ut;
                m_ctr[s][w]   = 2;
            end
        end
    endtask

    // Drive one cycle of stimulus, queue its expected response, then advance the model.
    task automatic cyc(input logic [PC_W-1:0] f, input bit uv, input logic [PC_W-1:0] upc,
                       input logic [PC_W-1:0] ut, input bit tk, input bit fr, input bit r);
        exp_t e;
        @(posedge clk);
        #1;
        fetch_pc      = f;
        update_valid  = uv;
        update_pc     = upc;
        update_target = ut;
        update_taken  = tk;
        flush_req     = fr;
        rst           = r;
        e.chk  = m_known;
        m_predict(f, e.hit, e.tgt);
        e.busy = (m_flush_left > 0);
        sb_q.push_back(e);
        m_step(r, fr, uv, upc, ut, tk);
    endtask

    task automatic fetch(input logic [PC_W-1:0] f);
        cyc(f, 0, '0, '0, 0, 0, 0);
    endtask

    task automatic upd(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] t, input bit tk);
        cyc(pc, 1, pc, t, tk, 0, 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.chk) begin
                n_tests++;
                if (btb_hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL hit pc=%h t=%0t: got %b expected %b", fetch_pc, $time, btb_hit, e.hit);
                end
                n_tests++;
                if (btb_target !== e.tgt) begin
                    n_fail++;
                    $display("FAIL target pc=%h t=%0t: got %h expected %h", fetch_pc, $time, btb_target, e.tgt);
                end
                n_tests++;
                if (flush_busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL flush_busy t=%0t: got %b expected %b", $time, flush_busy, e.busy);
                end
            end
        end
    end

    initial begin
        logic [PC_W-1:0] pc;
        cyc(10'h005, 0, '0, '0, 0, 0, 1);
        cyc(10'h005, 0, '0, '0, 0, 0, 1);
        fetch(10'h005);

        // Basic allocate and lookup, same-set miss
        upd(10'h005, 10'h040, 1);
        fetch(10'h005);
        fetch(10'h015);

        // Round-robin eviction, then a second eviction takes way 1
        upd(10'h015, 10'h111, 1);
        upd(10'h025, 10'h222, 1);
        fetch(10'h005);
        fetch(10'h015);
        fetch(10'h025);
        upd(10'h035, 10'h333, 1);
        fetch(10'h015);
        fetch(10'h025);
        fetch(10'h035);

        // Direction counter behaviour
        cyc('0, 0, '0, '0, 0, 0, 1);
        upd(10'h005, 10'h040, 1);
        upd(10'h005, 10'h040, 0);
        fetch(10'h005);
        upd(10'h005, 10'h050, 1);
        fetch(10'h005);
        upd(10'h005, 10'h060, 1);
        fetch(10'h005);
        upd(10'h005, 10'h060, 0);
        fetch(10'h005);
        upd(10'h015, 10'h070, 1);
        fetch(10'h015);

        // Flush walk with an update during it and a flush/update collision
        for (int i = 1; i < 8; i++) upd(PC_W'(i), PC_W'(i * 8), 1);
        cyc(10'h001, 1, 10'h009, 10'h099, 1, 1, 0);
        for (int i = 0; i < SETS + 2; i++) begin
            if (i == 3) cyc(10'h002, 1, 10'h00a, 10'h0aa, 1, 1, 0);
            else fetch(PC_W'(i % 8));
        end
        for (int i = 1; i < 10; i++) fetch(PC_W'(i));
        fetch(10'h00a);

        // Same-cycle update and lookup
        cyc(10'h007, 1, 10'h007, 10'h123, 1, 0, 0);
        fetch(10'h007);

        // Reset mid-flush
        upd(10'h00c, 10'h0cc, 1);
        cyc('0, 0, '0, '0, 0, 1, 0);
        fetch(10'h00c);
        fetch(10'h00c);
        cyc(10'h00c, 0, '0, '0, 0, 0, 1);
        fetch(10'h00c);
        upd(10'h00c, 10'h0dd, 1);
        fetch(10'h00c);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit uv, tk, fr, r;
            pc = PC_W'($urandom_range(0, 63));
            uv = ($urandom_range(0, 1) == 1);
            tk = ($urandom_range(0, 9) < 6);
            fr = ($urandom_range(0, 79) == 0);
            r  = ($urandom_range(0, 599) == 0);
            cyc(PC_W'($urandom_range(0, 63)), uv, pc, PC_W'($urandom), tk, fr, r);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/btb_assoc.md
# btb_assoc

Set-associative branch target buffer for the fetch stage, generalising the direct-mapped BTB to SETS × WAYS entries. Fetch queries it combinationally with the current fetch PC; branch resolution trains it with PC, target and taken outcome. Each set uses round-robin victim selection, and each entry carries an optional 2-bit direction counter. A multi-cycle flush walker clears the table one set per cycle, for example after a context switch or a self-modifying-code event.

## Interface
- PC_W, default INSTR_MEM_IDX_W: PC / target width; the tag is the full PC.
- SETS, default BTB_SETS (16): number of sets; power of 2, ≥2. SET_IDX_W = $clog2(SETS).
- WAYS, default BTB_WAYS (2): ways per set; power of 2, ≥1. WAYS=1 is direct-mapped.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- fetch_pc  in  PC_W  PC being looked up.
- btb_hit  out  1  valid tag match, with prediction taken.
- btb_target  out  PC_W  predicted target; '0 when btb_hit=0.
- update_valid  in  1  resolution strobe.
- update_pc  in  PC_W  resolved branch PC.
- update_target  in  PC_W  resolved target.
- update_taken  in  1  resolved direction.
- flush_req  in  1  single-cycle flush request.
- flush_busy  out  1  flush walk in progress.

## Operation
- Set index = pc[SET_IDX_W-1:0]. Each entry holds: valid, tag[PC_W], target[PC_W], ctr[1:0]. Each set also holds rr[$clog2(WAYS)] (omitted when WAYS=1).
- Lookup: compare fetch_pc against all ways of its set. If more than one way matches (cannot occur by construction), the lowest way index wins. btb_hit = match && predict, where predict is defined under Configuration.
- Update when update_valid is high and the FSM is IDLE:
  - Tag hit, taken: write target; ctr = sat_inc(ctr), saturating at 3.
  - Tag hit, not taken: ctr = sat_dec(ctr), saturating at 0.
  - Tag miss, taken: allocate a way. Choose the lowest-index invalid way if one exists; otherwise choose way rr and set rr = rr+1, wrapping mod WAYS. rr advances only on eviction. Write valid=1, tag=update_pc, target, ctr=2'b10.
  - Tag miss, not taken: no change.
- FSM states: IDLE and FLUSH, with a set counter fcnt[SET_IDX_W].
  - IDLE → FLUSH when flush_req=1; fcnt=0.
  - In FLUSH, each cycle clears valid, ctr and rr of set fcnt, then increments fcnt. When fcnt=SETS-1 the FSM returns to IDLE after clearing that set.
  - flush_req while in FLUSH is ignored.
- During FLUSH: btb_hit=0 for every PC, including sets not yet cleared, and updates are dropped.
- If flush_req and update_valid are high in the same cycle in IDLE, the flush wins and the update is dropped.
- Reset clears all valid, ctr and rr state in one cycle and forces IDLE. Tag and target contents need not be cleared. Reset mid-flush aborts the walk and returns to IDLE.

## Timing
- Lookup is combinational: zero-cycle latency from fetch_pc to btb_hit/btb_target.
- An update is written at the clock edge and is visible to lookups from the next cycle. A same-cycle lookup sees the pre-update contents; there is no bypass.
- A flush_req sampled at edge k produces flush_busy=1 for cycles k+1 … k+SETS, then 0. The first update accepted is at edge k+SETS+1.
- Reset values: btb_hit=0, btb_target='0, flush_busy=0.

## Configuration
- BTB_DIR_CTR_EN defined:
  - Counters are implemented.
  - predict = ctr[1], so an entry predicts taken only when ctr ≥ 2.
- BTB_DIR_CTR_EN undefined:
  - No ctr storage; predict = 1.
  - A taken tag hit rewrites the target.
  - A not-taken tag hit invalidates the entry. The freed way is picked first on the next allocation.

## Structure
- general_defines package adds:
  - BTB_SETS and BTB_WAYS.
  - btb_entry_t, a packed struct {valid, tag, target, ctr}.
  - btb_fsm_e enum {BTB_IDLE, BTB_FLUSH}.
- Sub-module btb_victim_sel: combinational. Takes a set's valid vector and rr and returns the victim way index plus an evict flag.

## Test plan
All scenarios use PC_W=10, SETS=16, WAYS=2, with BTB_DIR_CTR_EN defined unless stated.
- Reset, then fetch_pc=0x005 → btb_hit=0, btb_target=0, flush_busy=0.
- Update 0x005→0x040 taken; next cycle fetch 0x005 → hit=1, target=0x040. Fetch 0x015 (same set) → hit=0.
- Taken updates 0x005, 0x015, then 0x025 → 0x025 evicts way0, which held 0x005. Afterwards 0x005 misses while 0x015 and 0x025 hit, and rr for set 5 = 1.
- Allocate 0x005, then one not-taken update → ctr=01, hit=0. Then two taken updates → ctr=11, hit=1. With the macro undefined, a single not-taken update → miss.
- Fill several sets, pulse flush_req → flush_busy=1 for exactly 16 cycles. An update issued during the flush is dropped; afterwards every previously filled PC misses.
- Update and fetch 0x007 in the same cycle → hit=0 that cycle, hit=1 the next.
